tetris_sequencer: RTL and testbench

Piece sequencer for the 10×30 Tetris playfield. It owns the settled-block grid and the falling piece's anchor and shape mask, and drives the combinational collision checker with candidate positions. It applies the gravity tick and player moves, locks landed pieces, and clears full rows. It signals game over when a freshly spawned piece collides.

---
 rtl/tetris_sequencer_if.sv | 23 ++
 rtl/tetris_sequencer.sv | 247 ++++++++++++++++++++++++
 tb/tb_tetris_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/tetris_sequencer_if.sv
// Piece handshake and collision-checker bus for the Tetris sequencer.
// master = sequencer side, slave = shape source / combinational checker side.
interface tetris_sequencer_if #(
  parameter int CELLS = 300
);
  logic [11:0]      shape_in;
  logic             shape_valid;
  logic             shape_ready;
  logic [9:0]       chk_anchor;
  logic [11:0]      chk_mask;
  logic             chk_hit;
  logic [CELLS-1:0] grid;

  modport master (
    input  shape_in, shape_valid, chk_hit,
    output shape_ready, chk_anchor, chk_mask, grid
  );

  modport slave (
    output shape_in, shape_valid, chk_hit,
    input  shape_ready, chk_anchor, chk_mask, grid
  );
endinterface

// File: rtl/tetris_sequencer.sv
// Tetris piece sequencer: owns the settled grid and falling piece, drives the
// external collision checker, applies gravity/moves, locks pieces and clears rows.
module tetris_sequencer #(
    parameter int COLS      = 10,
    parameter int ROWS      = 30,
    parameter int SPAWN_COL = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 tick,
    input  logic                 mv_left,
    input  logic                 mv_right,
    input  logic                 hard_drop,
    tetris_sequencer_if.master   sif,
    output logic [9:0]           piece_anchor,
    output logic [11:0]          piece_mask,
    output logic                 piece_active,
    output logic [15:0]          lines_cleared,
    output logic                 game_over,
    output logic                 busy
);
    localparam int CELLS = ROWS * COLS;
    localparam logic [CELLS-1:0] ONE = CELLS'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_SPAWN, S_CHECK, S_WAIT, S_DROP, S_LOCK, S_CLEAR, S_OVER
    } state_t;

    typedef enum logic [2:0] {
        K_SPAWN, K_DOWN, K_LEFT, K_RIGHT, K_DROP
    } kind_t;

    state_t           state, state_n;
    kind_t            kind, kind_n;
    logic [4:0]       row, row_n;
    logic [3:0]       col, col_n;
    logic [11:0]      mask, mask_n;
    logic [5:0]       cand_row, cand_row_n;
    logic [5:0]       cand_col, cand_col_n;   // two's complement, may reach -1 or COLS
    logic [11:0]      cand_mask, cand_mask_n;
    logic [4:0]       scan_r, scan_n;
    logic [CELLS-1:0] grid, grid_n;
    logic [15:0]      lines, lines_n;

    logic             oob, hit, row_full;
    logic [9:0]       cand_anchor, cur_anchor;
    logic [CELLS-1:0] grid_lock, grid_shift, upto, row_sel;

    function automatic int off_row(input int k);
        case (k)
            0, 1, 2, 3, 4: return 0;
            5, 6, 7:       return 1;
            8, 9, 10:      return 2;
            default:       return 3;
        endcase
    endfunction

    function automatic int off_col(input int k);
        case (k)
            0, 5, 8:      return -1;
            2, 7, 10:     return 1;
            3:            return 2;
            4:            return 3;
            default:      return 0;
        endcase
    endfunction

    always_comb begin
        int c, r;
        c   = 0;
        r   = 0;
        oob = 1'b0;
        for (int unsigned k = 0; k < 12; k++) begin
            if (cand_mask[k]) begin
                c = int'($signed(cand_col)) + off_col(int'(k));
                r = int'(cand_row) + off_row(int'(k));
                if (c < 0 || c > COLS - 1 || r > ROWS - 1) oob = 1'b1;
            end
        end
    end

    assign hit         = sif.chk_hit | oob;
    assign cand_anchor = 10'(int'(cand_row) * COLS + int'($signed(cand_col)));
    assign cur_anchor  = 10'(int'(row) * COLS + int'(col));

    always_comb begin
        int base;
        base      = int'(row) * COLS + int'(col);
        grid_lock = grid;
        for (int unsigned k = 0; k < 12; k++) begin
            if (mask[k])
                grid_lock = grid_lock | (ONE << (base + off_row(int'(k)) * COLS + off_col(int'(k))));
        end
    end

    // Rows 0..r move down one row in a single shift; row 0 fills with zeros.
    always_comb begin
        row_sel    = grid >> (int'(scan_r) * COLS);
        row_full   = &row_sel[COLS-1:0];
        upto       = {CELLS{1'b1}} >> (CELLS - (int'(scan_r) + 1) * COLS);
        grid_shift = (grid & ~upto) | ((grid << COLS) & upto);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            kind      <= K_SPAWN;
            row       <= '0;
            col       <= '0;
            mask      <= '0;
            cand_row  <= '0;
            cand_col  <= '0;
            cand_mask <= '0;
            scan_r    <= '0;
            grid      <= '0;
            lines     <= '0;
        end else begin
            state     <= state_n;
            kind      <= kind_n;
            row       <= row_n;
            col       <= col_n;
            mask      <= mask_n;
            cand_row  <= cand_row_n;
            cand_col  <= cand_col_n;
            cand_mask <= cand_mask_n;
            scan_r    <= scan_n;
            grid      <= grid_n;
            lines     <= lines_n;
        end
    end

    always_comb begin
        state_n     = state;
        kind_n      = kind;
        row_n       = row;
        col_n       = col;
        mask_n      = mask;
        cand_row_n  = cand_row;
        cand_col_n  = cand_col;
        cand_mask_n = cand_mask;
        scan_n      = scan_r;
        grid_n      = grid;
        lines_n     = lines;
        case (state)
            S_IDLE, S_OVER: begin
                if (start) begin
                    grid_n  = '0;
                    lines_n = '0;
                    row_n   = '0;
                    col_n   = '0;
                    mask_n  = '0;
                    state_n = S_SPAWN;
                end
            end
            S_SPAWN: begin
                if (sif.shape_valid) begin
                    cand_row_n  = '0;
                    cand_col_n  = 6'(SPAWN_COL);
                    cand_mask_n = sif.shape_in;
                    kind_n      = K_SPAWN;
                    state_n     = S_CHECK;
                end
            end
            S_CHECK: begin
                if (hit) begin
                    case (kind)
                        K_SPAWN:         state_n = S_OVER;
                        K_LEFT, K_RIGHT: state_n = S_WAIT;
                        default:         state_n = S_LOCK;
                    endcase
                end else begin
                    row_n   = cand_row[4:0];
                    col_n   = cand_col[3:0];
                    mask_n  = cand_mask;
                    state_n = (kind == K_DROP) ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                cand_row_n  = {1'b0, row};
                cand_col_n  = {2'b00, col};
                cand_mask_n = mask;
                if (hard_drop) begin
                    cand_row_n = {1'b0, row} + 6'd1;
                    kind_n     = K_DROP;
                    state_n    = S_CHECK;
                end else if (tick) begin
                    cand_row_n = {1'b0, row} + 6'd1;
                    kind_n     = K_DOWN;
                    state_n    = S_CHECK;
                end else if (mv_left) begin
                    cand_col_n = {2'b00, col} - 6'd1;
                    kind_n     = K_LEFT;
                    state_n    = S_CHECK;
                end else if (mv_right) begin
                    cand_col_n = {2'b00, col} + 6'd1;
                    kind_n     = K_RIGHT;
                    state_n    = S_CHECK;
                end
            end
            S_DROP: begin
                cand_row_n  = {1'b0, row} + 6'd1;
                cand_col_n  = {2'b00, col};
                cand_mask_n = mask;
                kind_n      = K_DROP;
                state_n     = S_CHECK;
            end
            S_LOCK: begin
                grid_n  = grid_lock;
                scan_n  = 5'(ROWS - 1);
                state_n = S_CLEAR;
            end
            S_CLEAR: begin
                if (row_full) begin
                    grid_n  = grid_shift;
                    lines_n = lines + 16'd1;
                end else if (scan_r == '0) begin
                    state_n = S_SPAWN;
                end else begin
                    scan_n = scan_r - 5'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        sif.shape_ready = (state == S_SPAWN);
        sif.grid        = grid;
        game_over       = (state == S_OVER);
        piece_active    = (state inside {S_WAIT, S_CHECK, S_DROP});
        busy            = !(state inside {S_IDLE, S_WAIT, S_OVER});
        piece_anchor    = cur_anchor;
        piece_mask      = mask;
        lines_cleared   = lines;
        if (state == S_CHECK) begin
            sif.chk_anchor = cand_anchor;
            sif.chk_mask   = cand_mask;
        end else if (state inside {S_IDLE, S_SPAWN, S_OVER}) begin
            sif.chk_anchor = '0;
            sif.chk_mask   = '0;
        end else begin
            sif.chk_anchor = cur_anchor;
            sif.chk_mask   = mask;
        end
    end
endmodule

// File: tb/tb_tetris_sequencer.sv
// Directed bench for tetris_sequencer with a behavioural collision checker.
module tb_tetris_sequencer;
    logic clk = 1'b0;
    logic rst_n, start, tick, mv_left, mv_right, hard_drop;
    logic [9:0]  piece_anchor;
    logic [11:0] piece_mask;
    logic        piece_active, game_over, busy;
    logic [15:0] lines_cleared;
    logic        model_hit, force_hit;
    int checks = 0;
    int failures = 0;

    tetris_sequencer_if #(.CELLS(300)) sif ();

    tetris_sequencer #(.COLS(10), .ROWS(30), .SPAWN_COL(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tick(tick),
        .mv_left(mv_left), .mv_right(mv_right), .hard_drop(hard_drop),
        .sif(sif),
        .piece_anchor(piece_anchor), .piece_mask(piece_mask),
        .piece_active(piece_active), .lines_cleared(lines_cleared),
        .game_over(game_over), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int cell_off(input int k);
        case (k)
            0: return -1;  1: return 0;   2: return 1;   3: return 2;
            4: return 3;   5: return 9;   6: return 10;  7: return 11;
            8: return 19;  9: return 20;  10: return 21; default: return 30;
        endcase
    endfunction

    // Checker: overlap of candidate cells with settled grid (bounds handled by DUT).
    always_comb begin
        logic [299:0] sh;
        int idx;
        sh = '0;
        idx = 0;
        model_hit = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (sif.chk_mask[k]) begin
                idx = int'(sif.chk_anchor) + cell_off(k);
                if (idx >= 0 && idx < 300) begin
                    sh = sif.grid >> idx;
                    if (sh[0]) model_hit = 1'b1;
                end
            end
        end
    end

    assign sif.chk_hit = model_hit | force_hit;

    task automatic check(input string tag, input logic [299:0] got, input logic [299:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 0; tick = 0; mv_left = 0; mv_right = 0; hard_drop = 0;
        sif.shape_valid = 0; sif.shape_in = '0; force_hit = 0;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Returns one cycle after the CHECK cycle; chk_* are observed by caller via ck.
    task automatic spawn(input logic [11:0] shp, input bit ck);
        sif.shape_in = shp;
        sif.shape_valid = 1'b1;
        step();
        sif.shape_valid = 1'b0;
        if (ck) begin
            check("spawn_chk_anchor", 300'(sif.chk_anchor), 300'd4);
            check("spawn_chk_mask", 300'(sif.chk_mask), 300'(shp));
        end
        step();
    endtask

    task automatic pulse(input bit d, input bit t, input bit l, input bit r);
        hard_drop = d; tick = t; mv_left = l; mv_right = r;
        step();
        hard_drop = 0; tick = 0; mv_left = 0; mv_right = 0;
        step();
    endtask

    task automatic wait_spawn(input string tag, input int budget);
        int n = 0;
        while (!sif.shape_ready && n < budget) begin
            step();
            n++;
        end
        check(tag, 300'(sif.shape_ready), 300'd1);
    endtask

    task automatic move_to(input int target);
        if (target < 4) for (int i = 0; i < 4 - target; i++) pulse(0, 0, 1, 0);
        else            for (int i = 0; i < target - 4; i++) pulse(0, 0, 0, 1);
    endtask

    // O pieces at cols 0,2,4,6,8; optionally stop mid-CLEAR after the first cleared row.
    task automatic drop_five(input bit stop_mid);
        logic [299:0] e;
        int n;
        for (int p = 0; p < 5; p++) begin
            spawn(12'h0C6, 0);
            move_to(2 * p);
            if (p == 4 && stop_mid) begin
                pulse(1, 0, 0, 0);
                n = 0;
                while (lines_cleared != 16'd1 && n < 200) begin
                    step();
                    n++;
                end
                check("mid_clear_lines", 300'(lines_cleared), 300'd1);
                check("mid_clear_busy", 300'(busy), 300'd1);
            end else begin
                pulse(1, 0, 0, 0);
                wait_spawn("drop_spawn", 200);
            end
            if (p == 3) begin
                e = '0;
                for (int c = 0; c < 8; c++) begin
                    e[280 + c] = 1'b1;
                    e[290 + c] = 1'b1;
                end
                check("four_drops_grid", sif.grid, e);
                check("four_drops_lines", 300'(lines_cleared), 300'd0);
            end
        end
    endtask

    initial begin
        logic [299:0] e;
        e = '0;
        e[284] = 1'b1; e[285] = 1'b1; e[294] = 1'b1; e[295] = 1'b1;

        // Reset state and gravity to the floor
        do_reset();
        check("rst_anchor", 300'(piece_anchor), 300'd0);
        check("rst_grid", sif.grid, '0);
        check("rst_lines", 300'(lines_cleared), 300'd0);
        check("rst_busy", 300'(busy), 300'd0);
        check("rst_ready", 300'(sif.shape_ready), 300'd0);
        check("rst_chk_anchor", 300'(sif.chk_anchor), 300'd0);
        do_start();
        check("start_ready", 300'(sif.shape_ready), 300'd1);
        spawn(12'h0C6, 1);
        check("spawn_anchor", 300'(piece_anchor), 300'd4);
        check("spawn_active", 300'(piece_active), 300'd1);
        check("spawn_busy", 300'(busy), 300'd0);
        for (int i = 0; i < 28; i++) pulse(0, 1, 0, 0);
        check("tick28_anchor", 300'(piece_anchor), 300'd284);
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("tick29_cand", 300'(sif.chk_anchor), 300'd294);
        step();
        step();
        check("lock_grid", sif.grid, e);
        wait_spawn("tick_lock_spawn", 40);
        check("after_lock_grid", sif.grid, e);

        // Horizontal limits
        do_reset();
        do_start();
        spawn(12'h0C6, 0);
        for (int i = 0; i < 4; i++) pulse(0, 0, 1, 0);
        check("left4_anchor", 300'(piece_anchor), 300'd0);
        pulse(0, 0, 1, 0);
        check("left5_reject", 300'(piece_anchor), 300'd0);
        for (int i = 0; i < 8; i++) pulse(0, 0, 0, 1);
        check("right8_anchor", 300'(piece_anchor), 300'd8);
        pulse(0, 0, 0, 1);
        check("right9_reject", 300'(piece_anchor), 300'd8);

        // Two full rows cleared by hard drops
        do_reset();
        do_start();
        drop_five(0);
        check("clear2_lines", 300'(lines_cleared), 300'd2);
        check("clear2_grid", sif.grid, '0);

        // Spawn collision -> game over, then restart
        force_hit = 1'b1;
        spawn(12'h0C6, 0);
        force_hit = 1'b0;
        check("over_flag", 300'(game_over), 300'd1);
        check("over_ready", 300'(sif.shape_ready), 300'd0);
        check("over_lines_kept", 300'(lines_cleared), 300'd2);
        check("over_chk_anchor", 300'(sif.chk_anchor), 300'd0);
        do_start();
        check("restart_grid", sif.grid, '0);
        check("restart_lines", 300'(lines_cleared), 300'd0);
        check("restart_ready", 300'(sif.shape_ready), 300'd1);
        check("restart_over", 300'(game_over), 300'd0);

        // Request priority
        spawn(12'h0C6, 0);
        pulse(0, 1, 1, 0);
        check("tick_over_left", 300'(piece_anchor), 300'd14);
        pulse(1, 1, 0, 0);
        wait_spawn("drop_over_tick_spawn", 200);
        check("drop_over_tick_grid", sif.grid, e);

        // Reset in the middle of CLEAR
        do_reset();
        do_start();
        drop_five(1);
        rst_n = 1'b0;
        step();
        check("midrst_lines", 300'(lines_cleared), 300'd0);
        check("midrst_grid", sif.grid, '0);
        check("midrst_busy", 300'(busy), 300'd0);
        check("midrst_anchor", 300'(piece_anchor), 300'd0);
        check("midrst_ready", 300'(sif.shape_ready), 300'd0);
        rst_n = 1'b1;
        step();
        check("midrst_idle_busy", 300'(busy), 300'd0);
        check("midrst_idle_over", 300'(game_over), 300'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
